// File: rtl/tv80_regseq_pkg.sv
// Shared definitions for the TV80 register-pair sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
//   cmd_t   : one latched/queued command
//   PAIR_*  : register-file pair addresses used by block instructions
package tv80_regseq_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_ADD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] PAIR_BC = 3'd0;
  localparam logic [2:0] PAIR_DE = 3'd1;
  localparam logic [2:0] PAIR_HL = 3'd2;

  typedef struct packed {
    op_e         op;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  bmask;
  } cmd_t;

endpackage

// File: rtl/tv80_regseq_fifo.sv
// Generic synchronous FIFO with clock enable; used as the command queue.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   cen        : clock enable, all state holds when low
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, valid while empty_o is low
//   empty_o    : no entries
//   full_o     : DEPTH entries held
module tv80_regseq_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = cen & push_i & ~full_o;
  assign do_pop  = cen & pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count already make stale entries unreachable after a flush.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tv80_reg_pairseq.sv
// Register-pair sequencer in front of the TV80 8x16 register file.
// Accepts INC/DEC/LOAD/ADD pair commands, reads the pair on port B,
// writes the result back on port A and returns result plus zero/carry.
//   clk, reset, cen          : clock, sync active-high reset, clock enable
//   cmd_valid/ready/op/addr/data/bmask : command handshake and payload
//   rf_addra/addrb/dih/dil/weh/wel     : register-file control (registered)
//   rf_dobh/dobl             : async port B read data from the file
//   rsp_valid/data/zero/carry: one-cycle result pulse
// Build option: TV80_REGSEQ_QUEUE_EN adds an OPQ_DEPTH-entry command FIFO
// and lets RESP chain straight into the next command.
module tv80_reg_pairseq
  import tv80_regseq_pkg::*;
`ifdef TV80_REGSEQ_QUEUE_EN
#(
  parameter int OPQ_DEPTH = 2
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cen,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_bmask,
  output logic [2:0]  rf_addra,
  output logic [2:0]  rf_addrb,
  input  logic [7:0]  rf_dobh,
  input  logic [7:0]  rf_dobl,
  output logic [7:0]  rf_dih,
  output logic [7:0]  rf_dil,
  output logic        rf_weh,
  output logic        rf_wel,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_carry
);

  state_e      state_q;
  op_e         op_q;
  logic [2:0]  addr_q;
  logic [15:0] data_q;
  logic        carry_q;
  logic [2:0]  rf_addra_q, rf_addrb_q;
  logic [7:0]  rf_dih_q, rf_dil_q;
  logic        rf_weh_q, rf_wel_q;
  logic        rsp_valid_q, rsp_zero_q, rsp_carry_q;
  logic [15:0] rsp_data_q;

  cmd_t        in_cmd;
  cmd_t        src_cmd;
  logic        src_valid;
  logic        take;
  logic [16:0] alu_sum;
  logic [15:0] wr_word;

  assign in_cmd = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_data, bmask: cmd_bmask};

  // A new command may start from IDLE, or directly from RESP when queued.
  assign take = cen & src_valid & ((state_q == ST_IDLE) | (state_q == ST_RESP));

`ifdef TV80_REGSEQ_QUEUE_EN
  logic [$bits(cmd_t)-1:0] fifo_rdata;
  logic                    fifo_empty;
  logic                    fifo_full;

  tv80_regseq_fifo #(
    .DEPTH (OPQ_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_opq (
    .clk     (clk),
    .reset   (reset),
    .cen     (cen),
    .push_i  (cmd_valid),
    .wdata_i (in_cmd),
    .pop_i   (take),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign src_cmd   = cmd_t'(fifo_rdata);
  assign src_valid = ~fifo_empty;
  assign cmd_ready = ~fifo_full;
`else
  logic cmd_ready_q;

  assign src_cmd   = in_cmd;
  assign src_valid = cmd_valid & cmd_ready_q;
  assign cmd_ready = cmd_ready_q;
`endif

  // Pair arithmetic on the live port-B data; the result is captured at the
  // edge leaving READ, so the write-data registers double as the operand store.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_sum = {1'b0, rf_dobh, rf_dobl};
    case (op_q)
      OP_INC:  alu_sum = {1'b0, rf_dobh, rf_dobl} + 17'd1;
      OP_DEC:  alu_sum = {1'b0, rf_dobh, rf_dobl} - 17'd1;
      OP_ADD:  alu_sum = {1'b0, rf_dobh, rf_dobl} + {1'b0, data_q};
      default: alu_sum = {1'b0, rf_dobh, rf_dobl};
    endcase
  end

  // Bytes not written by a masked LOAD report as zero; INC/DEC/ADD write both.
  assign wr_word = {rf_weh_q ? rf_dih_q : 8'h00, rf_wel_q ? rf_dil_q : 8'h00};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INC;
      addr_q      <= '0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      rf_addra_q  <= '0;
      rf_addrb_q  <= '0;
      rf_dih_q    <= '0;
      rf_dil_q    <= '0;
      rf_weh_q    <= 1'b0;
      rf_wel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
`ifndef TV80_REGSEQ_QUEUE_EN
      cmd_ready_q <= 1'b1;
`endif
    end else if (cen) begin
      // Write enables and the response are single-state pulses.
      rf_weh_q    <= 1'b0;
      rf_wel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_READ: begin
          rf_addra_q           <= addr_q;
          {rf_dih_q, rf_dil_q} <= alu_sum[15:0];
          carry_q              <= alu_sum[16];
          rf_weh_q             <= 1'b1;
          rf_wel_q             <= 1'b1;
          state_q              <= ST_WRITE;
        end
        ST_WRITE: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= wr_word;
          rsp_zero_q  <= (wr_word == 16'h0000);
          rsp_carry_q <= carry_q;
          state_q     <= ST_RESP;
        end
        default: begin  // ST_IDLE, ST_RESP
`ifndef TV80_REGSEQ_QUEUE_EN
          cmd_ready_q <= ~take;
`endif
          if (take) begin
            op_q   <= src_cmd.op;
            addr_q <= src_cmd.addr;
            data_q <= src_cmd.data;
            if (src_cmd.op == OP_LOAD) begin
              // LOAD needs no read: go straight to WRITE with the payload.
              rf_addra_q           <= src_cmd.addr;
              {rf_dih_q, rf_dil_q} <= src_cmd.data;
              rf_weh_q             <= src_cmd.bmask[1];
              rf_wel_q             <= src_cmd.bmask[0];
              carry_q              <= 1'b0;
              state_q              <= ST_WRITE;
            end else begin
              rf_addrb_q <= src_cmd.addr;
              state_q    <= ST_READ;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rf_addra  = rf_addra_q;
  assign rf_addrb  = rf_addrb_q;
  assign rf_dih    = rf_dih_q;
  assign rf_dil    = rf_dil_q;
  assign rf_weh    = rf_weh_q;
  assign rf_wel    = rf_wel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_tv80_reg_pairseq.sv
// Self-checking bench for tv80_reg_pairseq: a behavioural TV80 register
// file drives the read port, and a pair-value reference model predicts
// every response and the final file contents.
module tb_tv80_reg_pairseq;
  import tv80_regseq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cen, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_bmask;
  logic [2:0]  cmd_addr, rf_addra, rf_addrb;
  logic [15:0] cmd_data, rsp_data;
  logic [7:0]  rf_dobh, rf_dobl, rf_dih, rf_dil;
  logic        rf_weh, rf_wel, rsp_valid, rsp_zero, rsp_carry;

  int total = 0;
  int bad   = 0;

`ifdef TV80_REGSEQ_QUEUE_EN
  localparam int LAT_ADD = 1;  // extra cycle through the command FIFO
`else
  localparam int LAT_ADD = 0;
`endif

  always #5 clk = ~clk;

  tv80_reg_pairseq dut (
    .clk       (clk),
    .reset     (reset),
    .cen       (cen),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_bmask (cmd_bmask),
    .rf_addra  (rf_addra),
    .rf_addrb  (rf_addrb),
    .rf_dobh   (rf_dobh),
    .rf_dobl   (rf_dobl),
    .rf_dih    (rf_dih),
    .rf_dil    (rf_dil),
    .rf_weh    (rf_weh),
    .rf_wel    (rf_wel),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
  );

  // Register file: split byte banks, async port B read, write on clk with CEN.
  logic [7:0] file_h [8];
  logic [7:0] file_l [8];
  assign rf_dobh = file_h[rf_addrb];
  assign rf_dobl = file_l[rf_addrb];
  always @(posedge clk) begin
    if (cen) begin
      if (rf_weh) file_h[rf_addra] <= rf_dih;
      if (rf_wel) file_l[rf_addra] <= rf_dil;
    end
  end

  // Reference: architectural pair values.
  logic [15:0] ref_pair [8];
  logic [17:0] last_rsp;   // {carry, zero, data} of the latest response
  logic [1:0]  last_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                           input logic [1:0] bm, output logic [15:0] r, output logic z,
                           output logic c, output logic [1:0] we);
    int unsigned cur, v;
    cur = 32'(ref_pair[a]);
    c   = 1'b0;
    we  = 2'b11;
    case (op)
      OP_INC: begin v = cur + 1;          c = (v > 65535); end
      OP_DEC: begin v = (cur == 0) ? 65535 : cur - 1; c = (cur == 0); end
      OP_ADD: begin v = cur + 32'(d);     c = (v > 65535); end
      default: begin
        we = bm;
        v  = {16'h0, bm[1] ? d[15:8] : 8'h00, bm[0] ? d[7:0] : 8'h00};
        ref_pair[a] = {bm[1] ? d[15:8] : ref_pair[a][15:8], bm[0] ? d[7:0] : ref_pair[a][7:0]};
      end
    endcase
    r = v[15:0];
    if (op != OP_LOAD) ref_pair[a] = r;
    z = (r == 16'h0000);
  endtask

  // Issue one command at a negedge and check its response; optionally
  // freeze cen for `hold` cycles in the first cycle after acceptance.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                         input logic [1:0] bm, input int hold);
    logic [15:0] er;
    logic        ez, ec;
    logic [1:0]  ewe, seen;
    int          lat, waited, we_cyc;
    model_cmd(op, a, d, bm, er, ez, ec, ewe);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_bmask = bm;
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
    check("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; seen = 2'b00; we_cyc = 0;
    if (hold > 0) begin
      cen = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_addrb", rf_addrb, a);
        check("hold_we", {rf_weh, rf_wel}, 0);
        check("hold_rsp", rsp_valid, 0);
      end
      cen = 1'b1;
    end
    while (1) begin
      if ((rf_weh || rf_wel) && seen == 2'b00) we_cyc = lat;
      seen |= {rf_weh, rf_wel};
      if (rsp_valid || lat >= 20) break;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, ((op == OP_LOAD) ? 2 : 3) + LAT_ADD);
    check("rsp_data", rsp_data, er);
    check("rsp_zero", rsp_zero, ez);
    check("rsp_carry", rsp_carry, ec);
    check("write_enables", seen, ewe);
    if (ewe != 2'b00) check("we_cycle", we_cyc, lat - 1);
    check("pair_value", {file_h[a], file_l[a]}, ref_pair[a]);
    last_rsp = {rsp_carry, rsp_zero, rsp_data};
    last_we  = seen;
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
  endtask

`ifdef TV80_REGSEQ_QUEUE_EN
  int          q_cyc [3];
  logic [15:0] q_val [3];
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seen_rsp;
    reset = 1'b1; cen = 1'b1; cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_addr = 3'd0; cmd_data = 16'h0; cmd_bmask = 2'b00;
    last_rsp = '0; last_we = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_we", {rf_weh, rf_wel}, 0);
    check("rst_addr", {rf_addra, rf_addrb}, 0);
    check("rst_di", {rf_dih, rf_dil}, 0);
    check("rst_rsp", {rsp_valid, rsp_zero, rsp_carry, rsp_data}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Give every pair a known value.
    for (int i = 0; i < 8; i++) run_cmd(OP_LOAD, 3'(i), 16'($urandom), 2'b11, 0);

    // DEC BC from 0x0001.
    run_cmd(OP_LOAD, PAIR_BC, 16'h0001, 2'b11, 0);
    run_cmd(OP_DEC, PAIR_BC, 16'h0000, 2'b00, 0);
    check("dec_bc_rsp", last_rsp, {1'b0, 1'b1, 16'h0000});
    check("dec_bc_pair", {file_h[0], file_l[0]}, 16'h0000);

    // INC HL wraps.
    run_cmd(OP_LOAD, PAIR_HL, 16'hFFFF, 2'b11, 0);
    run_cmd(OP_INC, PAIR_HL, 16'h0000, 2'b11, 0);
    check("inc_hl_rsp", last_rsp, {1'b1, 1'b1, 16'h0000});

    // ADD DE 0x8000 + 0x8001.
    run_cmd(OP_LOAD, PAIR_DE, 16'h8000, 2'b11, 0);
    run_cmd(OP_ADD, PAIR_DE, 16'h8001, 2'b00, 0);
    check("add_de_rsp", last_rsp, {1'b1, 1'b0, 16'h0001});

    // Low-byte-only LOAD over 0xAAAA.
    run_cmd(OP_LOAD, PAIR_DE, 16'hAAAA, 2'b11, 0);
    run_cmd(OP_LOAD, PAIR_DE, 16'h1234, 2'b01, 0);
    check("load_lo_rsp", last_rsp, {1'b0, 1'b0, 16'h0034});
    check("load_lo_we", last_we, 2'b01);
    check("load_lo_pair", {file_h[1], file_l[1]}, 16'hAA34);

    // No-write LOAD still responds.
    run_cmd(OP_LOAD, PAIR_HL, 16'h5555, 2'b00, 0);
    check("load_none_rsp", last_rsp, {1'b0, 1'b1, 16'h0000});

    // cen held low for 5 cycles right after acceptance.
    run_cmd(OP_LOAD, PAIR_BC, 16'h1234, 2'b11, 0);
    run_cmd(OP_INC, PAIR_BC, 16'h0000, 2'b00, 5);
    check("hold_result", last_rsp, {1'b0, 1'b0, 16'h1235});

    // Reset while a LOAD is in WRITE, then re-issue it.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = PAIR_DE; cmd_data = 16'hBEEF; cmd_bmask = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4 && !rf_weh; i++) @(negedge clk);
    check("abort_in_write", {rf_weh, rf_wel}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_we", {rf_weh, rf_wel}, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_rsp", rsp_valid, 0);
    seen_rsp = 2'b00;
    repeat (4) begin @(negedge clk); seen_rsp[0] |= rsp_valid; end
    check("abort_no_rsp", seen_rsp, 0);
    run_cmd(OP_LOAD, PAIR_DE, 16'hBEEF, 2'b11, 0);

`ifdef TV80_REGSEQ_QUEUE_EN
    begin
      int accepted, stalls, nrsp;
      logic [15:0] er;
      logic ez, ec;
      logic [1:0] ewe;
      run_cmd(OP_LOAD, PAIR_BC, 16'h00FE, 2'b11, 0);
      accepted = 0; stalls = 0; nrsp = 0;
      for (int c = 0; c < 40; c++) begin
        if (rsp_valid && nrsp < 3) begin q_cyc[nrsp] = c; q_val[nrsp] = rsp_data; nrsp++; end
        cmd_valid = (accepted < 3); cmd_op = OP_INC; cmd_addr = PAIR_BC; cmd_bmask = 2'b00;
        if (cmd_valid && !cmd_ready && accepted < 2) stalls++;
        if (cmd_valid && cmd_ready) accepted++;
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("q_stalls", stalls, 0);
      check("q_nrsp", nrsp, 3);
      for (int i = 0; i < 3; i++) begin
        model_cmd(OP_INC, PAIR_BC, 16'h0, 2'b00, er, ez, ec, ewe);
        check("q_rsp_data", q_val[i], er);
      end
      check("q_last", q_val[2], 16'h0101);
      check("q_gap0", q_cyc[1] - q_cyc[0], 3);
      check("q_gap1", q_cyc[2] - q_cyc[1], 3);
      check("q_pair", {file_h[0], file_l[0]}, ref_pair[0]);
    end
`endif

    // Randomised command mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'($urandom),
              2'($urandom_range(0, 3)), 0);
    end

    for (int i = 0; i < 8; i++) check("final_pair", {file_h[i], file_l[i]}, ref_pair[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tv80_reg_pairseq.md
Name: tv80_reg_pairseq

Overview:
- Sequencer that sits directly upstream of the TV80 8x16 register file (split H/L byte banks, one write port A, async read ports A/B/C).
- Accepts 16-bit register-pair commands over a valid/ready handshake and drives the file's AddrA/AddrB/DIH/DIL/WEH/WEL.
- Reads the pair via port B, computes, and writes back via port A. Used for block-instruction pair updates (BC--, HL++/--, DE++/--) and 16-bit loads.
- Returns the result plus zero/carry status.

Parameters:
- OPQ_DEPTH, 2, command queue depth when TV80_REGSEQ_QUEUE_EN is defined; power of two, 2..4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cen  in  1  clock enable; identical to the register file CEN
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready & cen
- cmd_op  in  2  0 INC, 1 DEC, 2 LOAD, 3 ADD
- cmd_addr  in  3  register-file pair address
- cmd_data  in  16  LOAD value, or ADD operand
- cmd_bmask  in  2  LOAD byte enables: [1] high, [0] low; ignored by other ops
- rf_addra  out  3  to AddrA
- rf_addrb  out  3  to AddrB
- rf_dobh  in  8  from DOBH
- rf_dobl  in  8  from DOBL
- rf_dih  out  8  to DIH
- rf_dil  out  8  to DIL
- rf_weh  out  1  to WEH
- rf_wel  out  1  to WEL
- rsp_valid  out  1  one-cycle pulse, result committed
- rsp_data  out  16  written value
- rsp_zero  out  1  rsp_data == 0
- rsp_carry  out  1  carry/borrow out of bit 15

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, cmd_ready 1, rf_* 0, rsp_* 0.
- FSM states: IDLE, READ, WRITE, RESP. Each state advances only on a clk edge with cen=1; with cen=0 every register holds.
- IDLE: on accept, latch op/addr/data/bmask. LOAD goes to WRITE; all other ops go to READ. cmd_ready is 0 outside IDLE.
- READ: rf_addrb = latched addr. The port B read is asynchronous, so {rf_dobh, rf_dobl} is captured into the operand register at the end of this cycle. Next state is WRITE.
- WRITE: rf_addra = addr, rf_dih/rf_dil = result, rf_weh/rf_wel asserted for exactly this state; the file writes at the edge leaving WRITE.
  - INC: operand + 1, carry on 0xFFFF -> 0x0000.
  - DEC: operand - 1, borrow on 0x0000 -> 0xFFFF.
  - ADD: operand + cmd_data, 17-bit sum, carry = bit 16.
  - LOAD: cmd_data; WEH = bmask[1], WEL = bmask[0]; carry 0. bmask = 0 is a legal no-write but still responds.
- RESP: rsp_valid = 1 for one cen-qualified cycle.
  - rsp_data = value written; for LOAD, masked-out bytes report 0.
  - rsp_zero and rsp_carry as defined above.
  - Next state is IDLE; cmd_ready returns to 1 in the same cycle.
- Latency from accept edge to rsp_valid: INC/DEC/ADD 3 cen cycles; LOAD 2.
- Throughput without the queue: one command per 4 (or 3 for LOAD) cen cycles.
- Reset mid-operation: the FSM returns to IDLE and WEH/WEL deassert at that edge. A write already committed stays committed; a pending write is dropped and no rsp is issued.
- A read in READ to the pair just written by the previous command sees the new value, because the write committed before RESP.

Optional Feature:
- TV80_REGSEQ_QUEUE_EN defined:
  - OPQ_DEPTH-entry command FIFO in front of the FSM; cmd_ready = FIFO not full.
  - RESP->IDLE is bypassed when the FIFO is non-empty: RESP goes directly to READ or WRITE for the head entry. Back-to-back INC/DEC/ADD then runs one command per 3 cen cycles.
  - Simultaneous push and pop when full is not allowed (ready=0); push and pop when non-full is allowed.
  - Reset flushes the FIFO.
- Undefined: no FIFO; behaviour exactly as in Behaviour.

Decomposition:
- Shared package tv80_regseq_pkg holds:
  - op encodings OP_INC/OP_DEC/OP_LOAD/OP_ADD
  - FSM state encodings
  - pair address constants PAIR_BC=0, PAIR_DE=1, PAIR_HL=2
- One sub-module, tv80_regseq_fifo: a generic synchronous FIFO, instantiated only under TV80_REGSEQ_QUEUE_EN.
- The 16-bit ALU stays inline.

Test Plan:
- Bench uses a tv80_reg model with BC preloaded to 0x0001. DEC BC -> WEH/WEL high in cycle 2 after accept, rsp_valid in cycle 3, rsp_data 0x0000, zero=1, carry=0; BC reads 0x0000.
- INC HL with HL=0xFFFF -> rsp_data 0x0000, zero=1, carry=1; ADD DE(0x8000)+0x8001 -> 0x0001, carry=1, zero=0.
- LOAD DE=0x1234, bmask=2'b01 over DE=0xAAAA -> only WEL pulses; DE=0xAA34; rsp_data 0x0034.
- Hold cen=0 for 5 cycles while in READ -> state, rf_* and operand frozen; the result is unchanged once cen returns.
- Assert reset during WRITE -> next cycle WEH=WEL=0, cmd_ready=1, no rsp_valid; re-issue completes normally.
- With TV80_REGSEQ_QUEUE_EN: 3 back-to-back INC BC from 0x00FE with cmd_valid held -> first two accepted without stall; responses 0x00FF, 0x0100, 0x0101 at 3-cycle spacing.
